// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC return path (fixed-point -> float):
//   - 3-bit FSM state encoding used by cordic_to_fp
//   - IEEE-754 single-precision field widths and exponent bias
//   - default CORDIC operand format (Q2.20 in a 22-bit word)
// No ports (package).
// -----------------------------------------------------------------------------
package cordic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_NORM = 3'd2,
      ST_PACK = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int FP_BIAS       = 127;
   localparam int FP_MANT_W     = 23;
   localparam int FP_EXP_W      = 8;
   localparam int CRD_WIDTH_DEF = 22;
   localparam int FRAC_BITS_DEF = 20;

endpackage

// File: rtl/crd_lzc.sv
// -----------------------------------------------------------------------------
// crd_lzc
// Combinational leading-zero counter for the CORDIC magnitude word.
// An all-zero input reports WIDTH.
// Ports:
//   i_data   in  WIDTH  word to scan (MSB first)
//   o_count  out CNT_W  number of leading zero bits
// -----------------------------------------------------------------------------
module crd_lzc #(
   parameter int WIDTH = 22,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [CNT_W-1:0] o_count
);

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      o_count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/cordic_to_fp.sv
// -----------------------------------------------------------------------------
// cordic_to_fp
// Converts a signed fixed-point CORDIC result into an IEEE-754 single float.
// The conversion is exact: the magnitude is normalised so its top bit is the
// hidden one, and the remaining bits are left-justified in the mantissa.
//
// Build option: CORDIC_TO_FP_FAST_NORM_EN
//   defined   -> normalisation in one cycle via a leading-zero count
//   undefined -> one-bit-per-cycle shift (latency depends on the input)
//
// Handshake: start is accepted only in IDLE while clk_en is high; crd_in is
// captured on that edge. busy is high in every non-IDLE state; done pulses
// for exactly one cycle when result is updated. start while busy is dropped.
//
// Ports:
//   clk          in   1               clock
//   rst          in   1               synchronous active-high reset
//   clk_en       in   1               qualifies start
//   start        in   1               conversion request
//   crd_in       in   CRD_WIDTH       signed fixed-point operand
//   result       out  FLT_DATA_WIDTH  float result, held until next done
//   busy         out  1               conversion in progress
//   done         out  1               one-cycle completion pulse
//   o_dbg_state  out  3               current FSM state (debug)
// -----------------------------------------------------------------------------
module cordic_to_fp
   import cordic_pkg::*;
#(
   parameter int FLT_DATA_WIDTH = 32,
   parameter int CRD_WIDTH      = CRD_WIDTH_DEF,
   parameter int FRAC_BITS      = FRAC_BITS_DEF,
   parameter int EXP_ADJ        = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clk_en,
   input  logic                      start,
   input  logic [CRD_WIDTH-1:0]      crd_in,
   output logic [FLT_DATA_WIDTH-1:0] result,
   output logic                      busy,
   output logic                      done,
   output logic [2:0]                o_dbg_state
);

   // Exponent of the unshifted word: its MSB weighs 2^(CRD_WIDTH-1-FRAC_BITS).
   localparam int EXP_INIT = FP_BIAS + (CRD_WIDTH - 1 - FRAC_BITS) + EXP_ADJ;

   state_t                      r_state;
   logic   [CRD_WIDTH-1:0]      r_crd;
   logic                        r_sign;
   logic   [CRD_WIDTH-1:0]      r_mag;
   logic   [FP_EXP_W-1:0]       r_exp;
   logic                        r_zero;
   logic   [FLT_DATA_WIDTH-1:0] r_result;

   logic   [CRD_WIDTH-1:0]      w_abs;
   logic   [FP_MANT_W-1:0]      w_mant;

   // Two's-complement negate; the most negative value maps onto itself,
   // which read as unsigned is exactly 2^(CRD_WIDTH-1).
   assign w_abs = r_crd[CRD_WIDTH-1] ? (~r_crd + 1'b1) : r_crd;

   // Bits below the hidden one, left-justified into the 23-bit field.
   generate
      if (CRD_WIDTH - 1 < FP_MANT_W) begin : g_mant_pad
         assign w_mant = {r_mag[CRD_WIDTH-2:0], {(FP_MANT_W - CRD_WIDTH + 1){1'b0}}};
      end else begin : g_mant_fit
         assign w_mant = r_mag[CRD_WIDTH-2 -: FP_MANT_W];
      end
   endgenerate

`ifdef CORDIC_TO_FP_FAST_NORM_EN
   localparam int LZC_W = $clog2(CRD_WIDTH + 1);
   logic [LZC_W-1:0] w_lzc;

   crd_lzc #(
      .WIDTH (CRD_WIDTH),
      .CNT_W (LZC_W)
   ) u_lzc (
      .i_data  (r_mag),
      .o_count (w_lzc)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_crd    <= '0;
         r_sign   <= 1'b0;
         r_mag    <= '0;
         r_exp    <= '0;
         r_zero   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && clk_en) begin
                  r_crd   <= crd_in;
                  r_state <= ST_ABS;
               end
            end
            ST_ABS: begin
               r_sign  <= r_crd[CRD_WIDTH-1];
               r_mag   <= w_abs;
               r_exp   <= FP_EXP_W'(EXP_INIT);
               r_zero  <= (w_abs == '0);
               r_state <= (w_abs == '0) ? ST_PACK : ST_NORM;
            end
            ST_NORM: begin
`ifdef CORDIC_TO_FP_FAST_NORM_EN
               r_mag   <= r_mag << w_lzc;
               r_exp   <= r_exp - FP_EXP_W'(w_lzc);
               r_state <= ST_PACK;
`else
               if (r_mag[CRD_WIDTH-1]) begin
                  r_state <= ST_PACK;
               end else begin
                  r_mag <= r_mag << 1;
                  r_exp <= r_exp - 1'b1;
               end
`endif
            end
            ST_PACK: begin
               r_result <= r_zero ? '0
                                  : FLT_DATA_WIDTH'({r_sign, r_exp, w_mant});
               r_state  <= ST_DONE;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign result      = r_result;
   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DONE);
   assign o_dbg_state = r_state;

endmodule
